mem_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared memory port of the pipelined core. Four requesters (0 = instruction fetch, 1 = load/store unit, 2 = debug, 3 = spare) share one memory request path through a 4-way WIDTH-bit select mux. This block picks the winner and drives the mux select `p`. It also sequences the request/response handshake with the memory and releases the port on response or timeout.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and handshake sequencer for the shared memory port.
// Picks one of four requesters, drives the mux select and releases on response or timeout.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       mem_valid,
    input  logic       mem_ready,
    input  logic       mem_resp,
    output logic [3:0] done,
    output logic       err,
    output logic       busy
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [1:0]    ptr, ptr_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    gnt_d;
    logic [1:0]    sel_d;
    logic          mem_valid_d;
    logic [3:0]    done_d;
    logic          err_d;
    logic          busy_d;

    // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] win_off;
    logic [1:0] win;
    logic       win_vld;

    always_comb begin
        req_dbl = {req, req};
        req_rot = 4'(req_dbl >> ptr);
        win_off = 2'd0;
        win_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 2'(i);
                win_vld = 1'b1;
            end
        end
        win = ptr + win_off;
    end

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        cnt_d       = '0;
        gnt_d       = gnt;
        sel_d       = sel;
        mem_valid_d = 1'b0;
        done_d      = 4'b0000;
        err_d       = 1'b0;

        case (state)
            ST_IDLE: begin
                gnt_d = 4'b0000;
                if (win_vld) begin
                    state_d     = ST_REQ;
                    gnt_d       = 4'b0001 << win;
                    sel_d       = win;
                    mem_valid_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_d = ST_WAIT;
                end else if (!req[sel]) begin
                    // Abort keeps ptr so the requester retains its priority.
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                end else begin
                    mem_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_resp) begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    done_d  = gnt;
                    ptr_d   = sel + 2'd1;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    err_d   = 1'b1;
                    ptr_d   = sel + 2'd1;
                end else begin
                    cnt_d = (&cnt) ? cnt : cnt + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= 2'd0;
            cnt       <= '0;
            gnt       <= 4'b0000;
            sel       <= 2'd0;
            mem_valid <= 1'b0;
            done      <= 4'b0000;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            sel       <= sel_d;
            mem_valid <= mem_valid_d;
            done      <= done_d;
            err       <= err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       mem_valid;
    logic       mem_ready;
    logic       mem_resp;
    logic [3:0] done;
    logic       err;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = idle, 1 = requesting, 2 = waiting for response
    int m_state, m_owner, m_ptr, m_wcnt, m_done, m_err;

    typedef struct {
        logic [3:0] req;
        logic       ready;
        logic       resp;
        logic [3:0] e_gnt;
        logic [1:0] e_sel;
        logic       e_valid;
        logic [3:0] e_done;
    } vec_t;

    vec_t tbl[15];

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_resp  (mem_resp),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_owner = 0; m_ptr = 0; m_wcnt = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit found;
        m_done = 0;
        m_err  = 0;
        case (m_state)
            0: if (req != 4'b0000) begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && req[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        found = 1;
                    end
                end
                m_state = 1;
            end
            1: begin
                if (mem_ready) begin
                    m_state = 2;
                    m_wcnt  = 0;
                end else if (!req[m_owner]) begin
                    m_state = 0;
                end
            end
            default: begin
                m_wcnt++;
                if (mem_resp) begin
                    m_done  = 1 << m_owner;
                    m_ptr   = (m_owner + 1) % 4;
                    m_state = 0;
                end else if (m_wcnt == TO) begin
                    m_err   = 1;
                    m_ptr   = (m_owner + 1) % 4;
                    m_state = 0;
                end
            end
        endcase
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "/gnt"},   32'(gnt),       (m_state != 0) ? 32'(1 << m_owner) : 32'd0);
        chk({tag, "/sel"},   32'(sel),       32'(m_owner));
        chk({tag, "/valid"}, 32'(mem_valid), 32'(m_state == 1));
        chk({tag, "/busy"},  32'(busy),      32'(m_state != 0));
        chk({tag, "/done"},  32'(done),      32'(m_done));
        chk({tag, "/err"},   32'(err),       32'(m_err));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        req = 4'b0000; mem_ready = 1'b0; mem_resp = 1'b0;
        #1;
        chk({tag, "/rst_gnt"},   32'(gnt),       32'd0);
        chk({tag, "/rst_sel"},   32'(sel),       32'd0);
        chk({tag, "/rst_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "/rst_done"},  32'(done),      32'd0);
        chk({tag, "/rst_err"},   32'(err),       32'd0);
        chk({tag, "/rst_busy"},  32'(busy),      32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full minimum-length transaction, expecting the given owner.
    task automatic txn(input string tag, input logic [3:0] r, input int owner);
        req = r; mem_ready = 1'b0; mem_resp = 1'b0;
        cycle(tag);
        chk({tag, "/txn_gnt"}, 32'(gnt), 32'(1 << owner));
        mem_ready = 1'b1;
        cycle(tag);
        mem_ready = 1'b0; mem_resp = 1'b1;
        cycle(tag);
        chk({tag, "/txn_done"}, 32'(done), 32'(1 << owner));
        mem_resp = 1'b0;
    endtask

    initial begin
        for (int t = 0; t < 5; t++) begin
            tbl[3*t]   = '{4'hF, 1'b0, 1'b0, 4'(1 << (t % 4)), 2'(t % 4), 1'b1, 4'h0};
            tbl[3*t+1] = '{4'hF, 1'b1, 1'b0, 4'(1 << (t % 4)), 2'(t % 4), 1'b0, 4'h0};
            tbl[3*t+2] = '{4'hF, 1'b0, 1'b1, 4'h0,             2'(t % 4), 1'b0, 4'(1 << (t % 4))};
        end

        do_reset("init");

        // Round-robin fairness with all requesters active
        for (int i = 0; i < 15; i++) begin
            req = tbl[i].req; mem_ready = tbl[i].ready; mem_resp = tbl[i].resp;
            cycle("tbl");
            chk("tbl/gnt",   32'(gnt),       32'(tbl[i].e_gnt));
            chk("tbl/sel",   32'(sel),       32'(tbl[i].e_sel));
            chk("tbl/valid", 32'(mem_valid), 32'(tbl[i].e_valid));
            chk("tbl/done",  32'(done),      32'(tbl[i].e_done));
        end
        mem_resp = 1'b0;

        // Wrap priority
        do_reset("wrap");
        txn("wrap", 4'hF, 0);
        txn("wrap", 4'hF, 1);
        txn("wrap", 4'hF, 2);
        txn("wrap", 4'hF, 3);
        txn("wrap", 4'b1010, 1);
        txn("wrap", 4'b1001, 3);

        // Abort in REQ keeps priority
        do_reset("abort");
        txn("abort", 4'b0001, 0);
        req = 4'b0010;
        cycle("abort");
        chk("abort/gnt1", 32'(gnt), 32'b0010);
        req = 4'b0000;
        cycle("abort");
        chk("abort/gnt0",  32'(gnt),       32'd0);
        chk("abort/valid", 32'(mem_valid), 32'd0);
        chk("abort/done",  32'(done),      32'd0);
        chk("abort/err",   32'(err),       32'd0);
        req = 4'b0011;
        cycle("abort");
        chk("abort/regnt", 32'(gnt), 32'b0010);
        chk("abort/resel", 32'(sel), 32'd1);
        mem_ready = 1'b1;
        cycle("abort");
        mem_ready = 1'b0; mem_resp = 1'b1;
        cycle("abort");
        mem_resp = 1'b0;

        // Reset mid-WAIT
        do_reset("rstw");
        req = 4'b0100;
        cycle("rstw");
        mem_ready = 1'b1;
        cycle("rstw");
        chk("rstw/inwait", 32'(gnt), 32'b0100);
        do_reset("rstw_mid");
        req = 4'b0001;
        cycle("rstw");
        chk("rstw/gnt", 32'(gnt), 32'b0001);
        chk("rstw/sel", 32'(sel), 32'd0);

        // Timeout after exactly TO WAIT cycles
        do_reset("tmo");
        req = 4'b0001;
        cycle("tmo");
        mem_ready = 1'b1;
        cycle("tmo");
        mem_ready = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            cycle("tmo");
            chk("tmo/hold_gnt", 32'(gnt), 32'b0001);
            chk("tmo/hold_err", 32'(err), 32'd0);
        end
        req = 4'b0011;
        cycle("tmo");
        chk("tmo/err",  32'(err),  32'd1);
        chk("tmo/gnt",  32'(gnt),  32'd0);
        chk("tmo/done", 32'(done), 32'd0);
        cycle("tmo");
        chk("tmo/err_pulse", 32'(err), 32'd0);
        chk("tmo/next_gnt",  32'(gnt), 32'b0010);

        // Response on the last WAIT cycle beats the timeout
        do_reset("race");
        req = 4'b0100;
        cycle("race");
        mem_ready = 1'b1;
        cycle("race");
        mem_ready = 1'b0;
        for (int i = 0; i < TO - 1; i++) cycle("race");
        mem_resp = 1'b1;
        cycle("race");
        chk("race/done", 32'(done), 32'b0100);
        chk("race/err",  32'(err),  32'd0);
        mem_resp = 1'b0;

        // Randomized run against the model
        do_reset("rand");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3, 0) == 0) req = 4'($urandom);
            mem_ready = ($urandom_range(2, 0) == 0);
            mem_resp  = ($urandom_range(4, 0) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
